// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C temperature poller.
package i2c_pkg;

  localparam int unsigned TEMP_W   = 12;
  localparam int unsigned TEMP_LSB = 4;

  // Sentinels: the first real sample always replaces both.
  localparam logic [TEMP_W-1:0] TEMP_MIN_INIT = 12'h7FF;
  localparam logic [TEMP_W-1:0] TEMP_MAX_INIT = 12'h800;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StReq      = 3'd1,
    StWaitBusy = 3'd2,
    StWaitData = 3'd3,
    StUpdate   = 3'd4
  } state_e;

endpackage

// File: rtl/temp_minmax_tracker.sv
// Signed running minimum/maximum of accepted temperature samples.
module temp_minmax_tracker
  import i2c_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     upd,
  input  logic signed [TEMP_W-1:0] sample,
  output logic signed [TEMP_W-1:0] temp_min,
  output logic signed [TEMP_W-1:0] temp_max
);

  logic signed [TEMP_W-1:0] min_q, min_d;
  logic signed [TEMP_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (upd) begin
      if (sample < min_q) min_d = sample;
      if (sample > max_q) max_d = sample;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_q <= TEMP_MIN_INIT;
      max_q <= TEMP_MAX_INIT;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign temp_min = min_q;
  assign temp_max = max_q;

endmodule

// File: rtl/i2c_temp_poller.sv
// Periodically triggers the I2C read master and publishes validated temperature samples.
// Optional macro I2C_TEMP_AVG_EN: temp reports a 4-sample moving average.
module i2c_temp_poller
  import i2c_pkg::*;
#(
  parameter int unsigned POLL_PERIOD    = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned BUSY_WAIT      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              err_clr,
  output logic              m_start,
  input  logic              m_busy,
  input  logic [15:0]       m_data,
  input  logic              m_data_valid,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_valid,
  output logic [TEMP_W-1:0] temp_min,
  output logic [TEMP_W-1:0] temp_max,
  output logic [15:0]       sample_cnt,
  output logic              err_timeout,
  output logic              err_abort
);

  localparam int unsigned PerW = $clog2(POLL_PERIOD + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BwW  = $clog2(BUSY_WAIT + 1);

  localparam logic [PerW-1:0] PerLast = PerW'(POLL_PERIOD - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [BwW-1:0]  BwLast  = BwW'(BUSY_WAIT - 1);

  state_e            state_q, state_d;
  logic [PerW-1:0]   per_q, per_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [BwW-1:0]    bw_q, bw_d;
  logic [TEMP_W-1:0] stage_q, stage_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              temp_valid_q, temp_valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_to_q, err_to_d;
  logic              err_ab_q, err_ab_d;
  logic              set_timeout, set_abort, upd;
  logic [TEMP_W-1:0] new_temp;
  logic              avg_ok;
  logic              unused_lsb;

  assign unused_lsb = ^m_data[TEMP_LSB-1:0];

  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    to_d        = to_q;
    bw_d        = bw_q;
    stage_d     = stage_q;
    set_timeout = 1'b0;
    set_abort   = 1'b0;
    upd         = 1'b0;
    case (state_q)
      StIdle: begin
        if (!enable) begin
          per_d = '0;
        end else if (per_q == PerLast) begin
          // Expired while the master is still busy: hold until it frees up.
          if (!m_busy) begin
            state_d = StReq;
            per_d   = '0;
          end
        end else begin
          per_d = per_q + PerW'(1);
        end
      end
      StReq: begin
        bw_d    = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (m_busy) begin
          to_d    = '0;
          state_d = StWaitData;
        end else if (bw_q == BwLast) begin
          set_abort = 1'b1;
          state_d   = StIdle;
        end else begin
          bw_d = bw_q + BwW'(1);
        end
      end
      StWaitData: begin
        // data_valid takes priority over a coincident busy fall.
        if (m_data_valid) begin
          stage_d = m_data[TEMP_LSB +: TEMP_W];
          state_d = StUpdate;
        end else if (!m_busy) begin
          set_abort = 1'b1;
          state_d   = StIdle;
        end else if (to_q == ToLast) begin
          set_timeout = 1'b1;
          state_d     = StIdle;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StUpdate: begin
        upd     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef I2C_TEMP_AVG_EN
  logic [TEMP_W-1:0]   hist0_q, hist1_q, hist2_q;
  logic [1:0]          fill_q;
  logic signed [TEMP_W+1:0] avg_sum, avg_shr;

  assign avg_sum = $signed({{2{stage_q[TEMP_W-1]}}, stage_q})
                 + $signed({{2{hist0_q[TEMP_W-1]}}, hist0_q})
                 + $signed({{2{hist1_q[TEMP_W-1]}}, hist1_q})
                 + $signed({{2{hist2_q[TEMP_W-1]}}, hist2_q});
  assign avg_shr  = avg_sum >>> 2;
  assign new_temp = avg_shr[TEMP_W-1:0];
  // Three earlier samples in history means the window is full.
  assign avg_ok   = (fill_q == 2'd3);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
      fill_q  <= '0;
    end else if (upd) begin
      hist0_q <= stage_q;
      hist1_q <= hist0_q;
      hist2_q <= hist1_q;
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
    end
  end
`else
  assign new_temp = stage_q;
  assign avg_ok   = 1'b1;
`endif

  always_comb begin
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    cnt_d        = cnt_q;
    err_to_d     = err_to_q;
    err_ab_d     = err_ab_q;
    if (upd) begin
      cnt_d = cnt_q + 16'd1;
      if (avg_ok) begin
        temp_d       = new_temp;
        temp_valid_d = 1'b1;
      end
    end
    // A new error in the same cycle as err_clr stays set.
    if (err_clr) begin
      err_to_d = 1'b0;
      err_ab_d = 1'b0;
    end
    if (set_timeout) err_to_d = 1'b1;
    if (set_abort)   err_ab_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      per_q        <= '0;
      to_q         <= '0;
      bw_q         <= '0;
      stage_q      <= '0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      cnt_q        <= '0;
      err_to_q     <= 1'b0;
      err_ab_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      to_q         <= to_d;
      bw_q         <= bw_d;
      stage_q      <= stage_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      cnt_q        <= cnt_d;
      err_to_q     <= err_to_d;
      err_ab_q     <= err_ab_d;
    end
  end

  temp_minmax_tracker u_minmax (
    .clk      (clk),
    .resetn   (resetn),
    .upd      (upd),
    .sample   (stage_q),
    .temp_min (temp_min),
    .temp_max (temp_max)
  );

  // Decoded from state so reset removes the pulse without waiting for a clock.
  assign m_start     = (state_q == StReq);
  assign temp        = temp_q;
  assign temp_valid  = temp_valid_q;
  assign sample_cnt  = cnt_q;
  assign err_timeout = err_to_q;
  assign err_abort   = err_ab_q;

endmodule

// File: tb/tb_i2c_temp_poller.sv
// Scoreboard bench for i2c_temp_poller with a scripted I2C master model.
module tb_i2c_temp_poller;

  localparam int unsigned PP = 32;
  localparam int unsigned TO = 50;
  localparam int unsigned BW = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        err_clr;
  logic        m_start;
  logic        m_busy;
  logic [15:0] m_data;
  logic        m_data_valid;
  logic [11:0] temp;
  logic        temp_valid;
  logic [11:0] temp_min;
  logic [11:0] temp_max;
  logic [15:0] sample_cnt;
  logic        err_timeout;
  logic        err_abort;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dv_cyc = 0;
  int tv_cnt = 0;
  int mdl_tv = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mdl_min, mdl_max, mdl_temp;
  logic [15:0] mdl_cnt;
`ifdef I2C_TEMP_AVG_EN
  logic [11:0] hist[$];
  int n_samp;
`endif

  i2c_temp_poller #(
    .POLL_PERIOD    (PP),
    .TIMEOUT_CYCLES (TO),
    .BUSY_WAIT      (BW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .err_clr      (err_clr),
    .m_start      (m_start),
    .m_busy       (m_busy),
    .m_data       (m_data),
    .m_data_valid (m_data_valid),
    .temp         (temp),
    .temp_valid   (temp_valid),
    .temp_min     (temp_min),
    .temp_max     (temp_max),
    .sample_cnt   (sample_cnt),
    .err_timeout  (err_timeout),
    .err_abort    (err_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_min  = 12'h7FF;
    mdl_max  = 12'h800;
    mdl_cnt  = 16'd0;
    mdl_temp = 12'd0;
    exp_q.delete();
`ifdef I2C_TEMP_AVG_EN
    hist.delete();
    n_samp = 0;
`endif
  endtask

  task automatic model_sample(input logic [11:0] raw);
    if ($signed(raw) < $signed(mdl_min)) mdl_min = raw;
    if ($signed(raw) > $signed(mdl_max)) mdl_max = raw;
    mdl_cnt = mdl_cnt + 16'd1;
`ifdef I2C_TEMP_AVG_EN
    begin
      logic signed [13:0] s;
      hist.push_back(raw);
      if (hist.size() > 4) void'(hist.pop_front());
      n_samp++;
      if (n_samp >= 4) begin
        s = 14'sd0;
        foreach (hist[i]) s = s + $signed({{2{hist[i][11]}}, hist[i]});
        s = s >>> 2;
        mdl_temp = s[11:0];
        exp_q.push_back(mdl_temp);
        mdl_tv++;
      end
    end
`else
    mdl_temp = raw;
    exp_q.push_back(raw);
    mdl_tv++;
`endif
  endtask

  // Every temp_valid pulse must match the oldest expected sample, 2 cycles after data_valid.
  always @(negedge clk) begin
    if (resetn === 1'b1 && temp_valid === 1'b1) begin
      tv_cnt++;
      check_eq("tv_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check_eq("temp", temp, exp_q.pop_front());
        check_eq("tv_latency", cyc - dv_cyc, 2);
      end
    end
  end

  task automatic check_reset(input string p);
    check_eq({p, "_m_start"}, m_start, 0);
    check_eq({p, "_temp"}, temp, 0);
    check_eq({p, "_temp_valid"}, temp_valid, 0);
    check_eq({p, "_temp_min"}, temp_min, 12'h7FF);
    check_eq({p, "_temp_max"}, temp_max, 12'h800);
    check_eq({p, "_sample_cnt"}, sample_cnt, 0);
    check_eq({p, "_err_timeout"}, err_timeout, 0);
    check_eq({p, "_err_abort"}, err_abort, 0);
  endtask

  task automatic check_stats(input string p);
    check_eq({p, "_min"}, temp_min, mdl_min);
    check_eq({p, "_max"}, temp_max, mdl_max);
    check_eq({p, "_cnt"}, sample_cnt, mdl_cnt);
    check_eq({p, "_tv_count"}, tv_cnt, mdl_tv);
  endtask

  task automatic wait_start(input int limit);
    int w;
    w = 0;
    while (m_start !== 1'b1 && w < limit) begin
      @(negedge clk);
      w++;
    end
    check_eq("start_seen", m_start, 1);
  endtask

  // Called at the negedge where m_start is visible; raises busy and checks the pulse width.
  task automatic ack_start();
    m_busy = 1'b1;
    @(negedge clk);
    check_eq("start_width", m_start, 0);
  endtask

  // data_valid coincides with busy falling: data must still be taken.
  task automatic respond_ok(input logic [15:0] data);
    repeat (2) @(negedge clk);
    m_data       = data;
    m_data_valid = 1'b1;
    m_busy       = 1'b0;
    dv_cyc       = cyc;
    model_sample(data[15:4]);
    @(negedge clk);
    m_data_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_poll(input logic [15:0] data);
    wait_start(4 * PP);
    ack_start();
    respond_ok(data);
  endtask

  task automatic wait_flag_timeout(input int limit, output int waited);
    waited = 0;
    while (err_timeout !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic wait_flag_abort(input int limit, output int waited);
    waited = 0;
    while (err_abort !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, w, n;
    resetn       = 1'b0;
    enable       = 1'b0;
    err_clr      = 1'b0;
    m_busy       = 1'b0;
    m_data       = 16'h0;
    m_data_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("rst");
    resetn = 1'b1;
    enable = 1'b1;

    do_poll(16'h1900);
    check_stats("basic");

    do_poll(16'hFF00);
    do_poll(16'h3200);
    check_stats("track");

    // Timeout: busy stays high, data never arrives.
    wait_start(4 * PP);
    s = cyc;
    ack_start();
    wait_flag_timeout(200, w);
    check_eq("timeout_at", cyc - s, TO + 2);
    check_eq("timeout_no_abort", err_abort, 0);
    m_busy  = 1'b0;
    s       = cyc;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("err_clr_timeout", err_timeout, 0);
    wait_start(4 * PP);
    check_eq("restart_gap", cyc - s, PP);
    ack_start();
    respond_ok(16'h0A50);
    check_stats("after_timeout");

    // Abort: busy falls after 10 cycles with no data.
    wait_start(4 * PP);
    m_busy = 1'b1;
    repeat (10) @(negedge clk);
    m_busy = 1'b0;
    wait_flag_abort(20, w);
    check_eq("abort_set", err_abort, 1);
    check_eq("abort_temp_kept", temp, mdl_temp);
    check_stats("abort");

    // Abort: busy never rises.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("err_clr_abort", err_abort, 0);
    wait_start(4 * PP);
    s = cyc;
    wait_flag_abort(20, w);
    check_eq("nobusy_abort_at", cyc - s, BW + 1);

    // Enable dropped mid-transfer: sample completes, then polling stops.
    wait_start(4 * PP);
    enable = 1'b0;
    ack_start();
    respond_ok(16'h0100);
    check_stats("disable");
    n = 0;
    for (int i = 0; i < 3 * int'(PP); i++) begin
      @(negedge clk);
      if (m_start === 1'b1) n++;
    end
    check_eq("no_start_disabled", n, 0);

    // Asynchronous reset while waiting for data.
    enable = 1'b1;
    wait_start(4 * PP);
    ack_start();
    repeat (4) @(negedge clk);
    #1;
    resetn = 1'b0;
    m_busy = 1'b0;
    #1;
    check_reset("rst_mid");
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // Asynchronous reset during the start pulse.
    wait_start(4 * PP);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("start_async_rst", m_start, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Low nibble is noise and must be ignored.
    do_poll(16'h1005);
    do_poll(16'h200F);
    do_poll(16'h3003);
    do_poll(16'h400C);
    check_stats("four");
`ifdef I2C_TEMP_AVG_EN
    check_eq("avg_temp", temp, 12'h280);
`else
    check_eq("raw_temp", temp, 12'h400);
`endif
    check_eq("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_temp_poller.md
Name: i2c_temp_poller

Overview:
- Downstream consumer and scheduler for the I2C read master.
- Periodically pulses the master's start input and waits for its 16-bit read result.
- Extracts a 12-bit two's-complement temperature from the left-justified word and tracks running min/max.
- Flags timeouts and aborted transfers, so the system side sees clean, validated samples only.

Parameters:
- POLL_PERIOD, 1000000, clk cycles from one start pulse to the next (must be ≥ 16).
- TIMEOUT_CYCLES, 200000, max clk cycles in WAIT_DATA before the transfer is abandoned.
- BUSY_WAIT, 4, max clk cycles after start for m_busy to rise.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  polling enabled when high
- err_clr  in  1  one-cycle pulse; clears the sticky error flags
- m_start  out  1  to master start; one-cycle pulse
- m_busy  in  1  from master busy
- m_data  in  16  from master data_out; bits[15:4] = temperature, bits[3:0] ignored
- m_data_valid  in  1  from master data_valid
- temp  out  12  signed temperature, 0.0625 °C/LSB
- temp_valid  out  1  one-cycle pulse when temp updates
- temp_min  out  12  signed running minimum
- temp_max  out  12  signed running maximum
- sample_cnt  out  16  count of good samples; wraps 0xFFFF→0
- err_timeout  out  1  sticky; WAIT_DATA exceeded TIMEOUT_CYCLES
- err_abort  out  1  sticky; busy fell without data_valid, or busy never rose

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values: m_start=0, temp=0, temp_valid=0, temp_min=0x7FF, temp_max=0x800, sample_cnt=0, err_*=0, state=IDLE, period counter=0.
- IDLE
  - Period counter increments each cycle while enable=1; held at 0 while enable=0.
  - When counter==POLL_PERIOD-1 and m_busy==0: go to REQ and clear the counter.
  - If m_busy==1 at expiry: counter holds at its final value until busy drops.
- REQ: m_start=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY
  - m_busy==1 → WAIT_DATA.
  - BUSY_WAIT cycles elapse with busy still low → set err_abort, go to IDLE.
- WAIT_DATA
  - m_data_valid==1 → capture m_data[15:4] into the staging register, go to UPDATE.
  - m_busy falls with no data_valid → set err_abort, go to IDLE.
  - Timeout counter reaches TIMEOUT_CYCLES-1 → set err_timeout, go to IDLE. m_start is not re-pulsed until the next period.
  - Simultaneous m_data_valid and busy-fall → data_valid wins.
- UPDATE (one cycle)
  - temp <= staged value.
  - temp_valid=1 in the following cycle, aligned with the new temp.
  - Signed compare: temp_min <= min(temp_min, staged); temp_max <= max(temp_max, staged).
  - sample_cnt increments.
  - Return to IDLE.
- Latency: m_data_valid high → temp_valid high 2 cycles later.
- First sample after reset sets both temp_min and temp_max to that sample, via the sentinel reset values.
- enable low mid-transfer: the current transfer completes normally; no new start is issued afterwards.
- Errors are not cleared by a later good sample. err_clr clears both flags; if an error and err_clr occur in the same cycle, the error set wins.
- Asynchronous reset mid-transfer: returns to IDLE immediately. m_start deasserts asynchronously.
- States encoded in 3 bits: IDLE, REQ, WAIT_BUSY, WAIT_DATA, UPDATE.

Optional Feature:
- Macro: I2C_TEMP_AVG_EN.
- Defined:
  - temp outputs a 4-sample moving average: sum of the last 4 samples in 14-bit signed, arithmetic shift right by 2.
  - temp_valid is suppressed until 4 samples have been taken since reset.
  - min/max still track raw samples.
- Undefined: temp is the raw sample. No history registers are generated.

Decomposition:
- Shared package i2c_pkg:
  - state encoding localparams
  - TEMP_W=12, TEMP_LSB=4
  - TEMP_MIN_INIT=12'h7FF, TEMP_MAX_INIT=12'h800
- One natural sub-module: temp_minmax_tracker (signed compare-and-hold, sentinel reset). The FSM, counters and averaging stay in the top module.

Test Plan:
- Basic poll: POLL_PERIOD=32, master model returns 0x1900 → one m_start pulse; temp=0x190 (25.0 °C), temp_valid pulses once 2 cycles after data_valid; min=max=0x190; sample_cnt=1.
- Negative and tracking: returns 0x1900, 0xFF00, 0x3200 → temp_min=0xFF0, temp_max=0x320, sample_cnt=3.
- Timeout: master raises busy and never asserts data_valid, TIMEOUT_CYCLES=50 → err_timeout=1 at cycle 50 of WAIT_DATA; next start issued one period later; err_clr clears the flag.
- Abort: busy high 10 cycles, then low without data_valid → err_abort=1, temp unchanged, no temp_valid.
- Reset and enable: resetn pulled low during WAIT_DATA → all outputs return to reset values. Drop enable during a transfer → that sample still completes, then no further m_start.
- With I2C_TEMP_AVG_EN: samples 0x100, 0x200, 0x300, 0x400 (12-bit) → first temp_valid only after the 4th sample, temp=0x280.
